// File: rtl/parity_pkg.sv
// Shared types and the parity helper for the parity stream generator.
// Parity is even when typ is EVEN_PAR, or the inverted XOR when typ is ODD_PAR.
package parity_pkg;

  typedef enum logic {EVEN_PAR = 1'b0, ODD_PAR = 1'b1} par_t;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // Callers zero-extend narrower fields; zero padding leaves the XOR unchanged.
  localparam int PAR_FN_W = 256;

  function automatic logic par_calc(input logic [PAR_FN_W-1:0] data, input par_t typ);
    return (^data) ^ (typ == ODD_PAR);
  endfunction

endpackage

// File: rtl/parity_stream_gen_seg_parity.sv
// Combinational per-segment parity array: one parity bit for each SEG_WIDTH-bit
// slice of the beat, all under the same parity type.
module seg_parity
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEG_WIDTH  = 8,
  localparam int NSEG      = DATA_WIDTH / SEG_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  par_t                  typ,
  output logic [NSEG-1:0]       seg_par
);

  for (genvar i = 0; i < NSEG; i++) begin : g_seg
    assign seg_par[i] = par_calc({{(PAR_FN_W-SEG_WIDTH){1'b0}}, data[i*SEG_WIDTH +: SEG_WIDTH]}, typ);
  end

endmodule

// File: rtl/parity_stream_gen.sv
// Streaming parity generator: per-segment parity on every beat plus a running
// burst parity reported on the last beat, behind a single backpressured output register.
module parity_stream_gen
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEG_WIDTH  = 8,
  parameter int MAX_BURST  = 16,
  localparam int NSEG      = DATA_WIDTH / SEG_WIDTH,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  par_typ,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NSEG-1:0]       out_seg_par,
  output logic                  out_last,
  output logic                  out_burst_par,
  output logic                  ovf_err,
  input  logic                  err_clr
);

  state_t            state_q;
  par_t              typ_q;
  logic              acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept_p0;
  logic              first_beat_p0;
  par_t              typ_p0;
  logic              beat_x_p0;
  logic              acc_base_p0;
  logic [CNT_W-1:0]  cnt_nxt_p0;
  logic              forced_p0;
  logic              burst_end_p0;
  logic              burst_par_p0;
  logic [NSEG-1:0]   seg_par_p0;

  // Stage p0: combinational beat evaluation against the current burst state
  assign in_ready      = rst && (!out_valid || out_ready);
  assign accept_p0     = in_valid && in_ready;
  assign first_beat_p0 = (state_q == IDLE);
  assign typ_p0        = first_beat_p0 ? par_t'(par_typ) : typ_q;
  assign beat_x_p0     = ^in_data;
  assign acc_base_p0   = first_beat_p0 ? 1'b0 : acc_q;
  assign cnt_nxt_p0    = first_beat_p0 ? CNT_W'(1) : cnt_q + 1'b1;
  assign forced_p0     = (cnt_nxt_p0 == CNT_W'(MAX_BURST)) && !in_last;
  assign burst_end_p0  = in_last || forced_p0;
  assign burst_par_p0  = acc_base_p0 ^ beat_x_p0 ^ (typ_p0 == ODD_PAR);

  seg_parity #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEG_WIDTH  (SEG_WIDTH)
  ) u_seg_parity (
    .data    (in_data),
    .typ     (typ_p0),
    .seg_par (seg_par_p0)
  );

  // Burst tracking: accumulator and count are cleared whenever a burst closes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      typ_q   <= EVEN_PAR;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (accept_p0) begin
      if (first_beat_p0) typ_q <= typ_p0;
      if (burst_end_p0) begin
        state_q <= IDLE;
        acc_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= BURST;
        acc_q   <= acc_base_p0 ^ beat_x_p0;
        cnt_q   <= cnt_nxt_p0;
      end
    end
  end

  // Stage p1: output register; holds while stalled, drops valid once consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_seg_par   <= '0;
      out_last      <= 1'b0;
      out_burst_par <= 1'b0;
    end else if (accept_p0) begin
      out_valid     <= 1'b1;
      out_data      <= in_data;
      out_seg_par   <= seg_par_p0;
      out_last      <= burst_end_p0;
      out_burst_par <= burst_end_p0 & burst_par_p0;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_burst_par <= 1'b0;
    end
  end

  // A forced termination in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err <= 1'b0;
    end else if (accept_p0 && forced_p0) begin
      ovf_err <= 1'b1;
    end else if (err_clr) begin
      ovf_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_stream_gen.sv
// Bench for parity_stream_gen: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a burst-level reference model.
module tb_parity_stream_gen;

  localparam int DW = 32;
  localparam int SW = 8;
  localparam int MB = 4;
  localparam int NS = DW / SW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          par_typ = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [NS-1:0] out_seg_par;
  logic          out_last;
  logic          out_burst_par;
  logic          ovf_err;
  logic          err_clr = 1'b0;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parity_stream_gen #(
    .DATA_WIDTH (DW),
    .SEG_WIDTH  (SW),
    .MAX_BURST  (MB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .par_typ       (par_typ),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_seg_par   (out_seg_par),
    .out_last      (out_last),
    .out_burst_par (out_burst_par),
    .ovf_err       (ovf_err),
    .err_clr       (err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected output beats in order, plus burst bookkeeping
  typedef struct {
    logic [DW-1:0] data;
    logic [NS-1:0] seg;
    logic          last;
    logic          bpar;
  } beat_t;

  beat_t q[$];
  int    m_beats = 0;
  int    m_ones  = 0;
  logic  m_typ   = 1'b0;
  logic  m_ovf   = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        m_beats = 0;
        m_ones  = 0;
        m_ovf   = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_seg_par", 32'(out_seg_par), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_burst_par", 32'(out_burst_par), 0);
        chk("rst_ovf_err", 32'(ovf_err), 0);
      end else begin
        logic forced;
        beat_t e;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        if (out_valid && q.size() != 0) begin
          chk("out_data", out_data, q[0].data);
          chk("out_seg_par", 32'(out_seg_par), 32'(q[0].seg));
          chk("out_last", 32'(out_last), 32'(q[0].last));
          chk("out_burst_par", 32'(out_burst_par), 32'(q[0].bpar));
          if (out_ready) void'(q.pop_front());
        end else begin
          chk("idle_burst_par", 32'(out_burst_par), 0);
        end
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        forced = 1'b0;
        if (in_valid && in_ready) begin
          if (m_beats == 0) begin
            m_typ  = par_typ;
            m_ones = 0;
          end
          m_beats++;
          m_ones += $countones(in_data);
          for (int i = 0; i < NS; i++)
            e.seg[i] = 1'(($countones(in_data[i*SW +: SW]) + int'(m_typ)) % 2);
          forced = (m_beats == MB) && !in_last;
          e.data = in_data;
          e.last = in_last || forced;
          e.bpar = e.last ? 1'(((m_ones + int'(m_typ)) % 2)) : 1'b0;
          if (e.last) m_beats = 0;
          q.push_back(e);
        end
        if (forced) m_ovf = 1'b1;
        else if (err_clr) m_ovf = 1'b0;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic last, input logic typ);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    par_typ  = typ;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [NS-1:0] seg, input logic last, input logic bpar);
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 1);
    chk({name, "_seg"}, 32'(out_seg_par), 32'(seg));
    chk({name, "_last"}, 32'(out_last), 32'(last));
    chk({name, "_bpar"}, 32'(out_burst_par), 32'(bpar));
  endtask

  initial begin
    // Reset held with a valid beat offered
    in_valid = 1'b1;
    in_data  = 32'h0000_00AB;
    in_last  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 1);

    // Single-beat bursts, even then odd
    send(32'h0000_00AB, 1'b1, 1'b0);
    expect_out("single_even", 4'b0001, 1'b1, 1'b1);
    send(32'h0000_00AB, 1'b1, 1'b1);
    expect_out("single_odd", 4'b1110, 1'b1, 1'b0);

    // Two-beat burst; par_typ toggled on the second beat is ignored
    send(32'h0000_0001, 1'b0, 1'b0);
    expect_out("two_b1", 4'b0001, 1'b0, 1'b0);
    send(32'h0000_0003, 1'b1, 1'b1);
    expect_out("two_b2", 4'b0000, 1'b1, 1'b1);

    // Backpressure for 3 cycles in a 3-beat burst: 3 + 1 + 1 ones -> even parity 1
    send(32'h0000_0007, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0100;
    in_last   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold_data", out_data, 32'h0000_0007);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_b2_data", out_data, 32'h0000_0100);
    send(32'h0000_0001, 1'b1, 1'b0);
    expect_out("bp_end", 4'b0001, 1'b1, 1'b1);

    // Overflow: four beats without last force termination
    repeat (3) send(32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0001, 1'b0, 1'b0);
    expect_out("ovf_b4", 4'b0001, 1'b1, 1'b0);
    chk("ovf_set", 32'(ovf_err), 1);
    send(32'h0000_0001, 1'b0, 1'b0);
    expect_out("ovf_b5", 4'b0001, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(ovf_err), 1);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(ovf_err), 0);
    send(32'h0000_0001, 1'b1, 1'b0);
    expect_out("ovf_close", 4'b0001, 1'b1, 1'b0);

    // Reset mid-burst discards the partial burst
    send(32'h0000_0003, 1'b0, 1'b1);
    send(32'h0000_0005, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send(32'h0000_0001, 1'b1, 1'b0);
    expect_out("post_rst", 4'b0001, 1'b1, 1'b1);

    // Randomized traffic with backpressure and error clears
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom();
      in_last   = ($urandom_range(0, 3) == 0);
      par_typ   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/parity_stream_gen.md
Name: parity_stream_gen

Overview:
Streaming parity generator, the parametrised successor to the single-word parity_gen. It computes per-segment parity on every beat of a valid/ready data stream and accumulates a running burst parity that is reported on the last beat. It supports even/odd selection latched per burst, burst-length limiting with an overflow flag, and a registered output stage with backpressure. It sits between a packet source and a serial/link framer.

Parameters:
DATA_WIDTH, 32, beat width in bits; must be a multiple of SEG_WIDTH.
SEG_WIDTH, 8, segment width for per-segment parity; NSEG = DATA_WIDTH/SEG_WIDTH.
MAX_BURST, 16, maximum beats per burst; must be >= 2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
par_typ  in  1  0 = even, 1 = odd; sampled on the first beat of each burst
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  DATA_WIDTH  beat data
in_last  in  1  final beat of burst
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  DATA_WIDTH  registered copy of in_data
out_seg_par  out  NSEG  bit i = parity of in_data[i*SEG_WIDTH +: SEG_WIDTH] under the latched par_typ
out_last  out  1  burst end, either from in_last or forced
out_burst_par  out  1  parity over all burst bits under the latched type; valid only when out_valid && out_last, otherwise 0
ovf_err  out  1  sticky flag: a burst was force-terminated
err_clr  in  1  synchronous clear of ovf_err

Behaviour:
- Reset (rst=0, async): out_valid, out_data, out_seg_par, out_last, out_burst_par, ovf_err = 0. State = IDLE, beat counter = 0, accumulator = 0. in_ready is forced to 0 while rst=0.
- Handshake: in_ready = !out_valid || out_ready (combinational; single output register with no skid). An accepted beat appears on the outputs on the next cycle, giving 1-cycle latency. When out_valid=1 and out_ready=0, all outputs hold stable.
- Parity definition: even bit = XOR of the covered bits; odd bit = inverted XOR. For example, 8'hAB gives even 1, odd 0.
- FSM IDLE -> BURST:
  - IDLE: an accepted beat latches par_typ into typ_q and sets cnt=1 and acc = XOR(in_data). If in_last=1, the burst is single-beat and the state stays IDLE; otherwise the state moves to BURST.
  - BURST: each accepted beat uses typ_q and ignores par_typ, sets acc ^= XOR(in_data), and increments cnt. If in_last=1, or the forced limit applies, the state returns to IDLE and acc and cnt are cleared.
- Forced termination: if an accepted beat has cnt+1 == MAX_BURST and in_last=0, then out_last=1, out_burst_par is computed normally, ovf_err is set, and the state returns to IDLE. The next beat starts a new burst.
- ovf_err: it is set by a forced termination and cleared by err_clr=1 on the next edge. If set and clear occur in the same cycle, set wins.
- out_burst_par = XOR(acc_before_beat) ^ XOR(last beat) ^ typ_q, or ^ par_typ for a single-beat burst.
- out_seg_par on every beat uses the burst's latched type (par_typ for the first beat).
- Counter width is $clog2(MAX_BURST+1); it never wraps.
- If rst is asserted mid-burst, the partial burst is discarded with no output and no error.
- in_valid=0 cycles within a burst are allowed. State, acc and cnt hold.

Decomposition:
- Package parity_pkg holds typedef enum logic {EVEN_PAR, ODD_PAR} par_t, typedef enum logic {IDLE, BURST} state_t, and function par_calc(data, typ).
- One sub-module, seg_parity: a combinational, width-parametrised segment-parity array producing NSEG bits, instantiated once.

Test Plan:
All scenarios use DATA_WIDTH=32, SEG_WIDTH=8, MAX_BURST=4.
1. Reset: hold rst=0 with in_valid=1 -> all outputs 0 and in_ready=0. Release rst -> in_ready=1 next cycle.
2. Single beat: 32'h0000_00AB, last=1, par_typ=0 -> next cycle out_seg_par=4'b0001, out_burst_par=1, out_last=1. The same beat with par_typ=1 -> out_seg_par=4'b1110, out_burst_par=0.
3. Two-beat burst: 32'h01, 32'h03 (last), par_typ=0. par_typ toggles to 1 on beat 2 -> beat 2 out_seg_par=4'b0000 and out_burst_par=1, using the latched even type.
4. Backpressure: out_ready=0 for 3 cycles during a 3-beat burst -> in_ready=0, outputs stable, no beat lost or duplicated, correct out_burst_par at the end.
5. Overflow: 5 beats of 32'h1 with no last -> beat 4 has out_last=1, out_burst_par=0, ovf_err=1. Beat 5 starts a new burst. err_clr=1 -> ovf_err=0 next cycle.
6. Reset mid-burst: assert rst after beat 2 of a burst, release, then send 32'h1 last -> out_burst_par=1, with no residue from the aborted burst.
